// File: rtl/sound_mixer_gain_if.sv
// sound_mixer_gain_if: sample, gain-write and result signals between a controller and the mixer
interface sound_mixer_gain_if #(
    parameter int COUNT      = 4,
    parameter int IN_WIDTH   = 10,
    parameter int OUT_WIDTH  = 10,
    parameter int GAIN_WIDTH = 8
);
    localparam int IW = COUNT > 1 ? $clog2(COUNT) : 1;
    logic [COUNT*IN_WIDTH-1:0]    in_i;
    logic                         start_i;
    logic                         gain_we_i;
    logic [IW-1:0]                gain_addr_i;
    logic [GAIN_WIDTH-1:0]        gain_data_i;
    logic                         clip_clr_i;
    logic                         busy_o;
    logic signed [OUT_WIDTH-1:0]  out_o;
    logic                         out_valid_o;
    logic                         clip_o;
    modport master (
        output in_i, start_i, gain_we_i, gain_addr_i, gain_data_i, clip_clr_i,
        input  busy_o, out_o, out_valid_o, clip_o
    );
    modport slave (
        input  in_i, start_i, gain_we_i, gain_addr_i, gain_data_i, clip_clr_i,
        output busy_o, out_o, out_valid_o, clip_o
    );
endinterface

// File: rtl/sound_mixer_gain.sv
// sound_mixer_gain: COUNT-channel gain mixer with one shared MAC and output saturation.
// Define SOUND_MIXER_CLIP_EN to build the sticky CLIP flag.
module sound_mixer_gain #(
    parameter int COUNT      = 4,
    parameter int IN_WIDTH   = 10,
    parameter int OUT_WIDTH  = 10,
    parameter int GAIN_WIDTH = 8
) (
    input logic clk_i,
    input logic rst_i,
    sound_mixer_gain_if.slave bus
);
    localparam int IW = COUNT > 1 ? $clog2(COUNT) : 1;
    localparam int AW = IN_WIDTH + GAIN_WIDTH + 1 + $clog2(COUNT + 1);
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1) << (GAIN_WIDTH - 1);
    localparam logic signed [AW-1:0] OMAX = AW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] OMIN = -OMAX - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, LIMIT} state_t;

    state_t                          state_q;
    logic [IW-1:0]                   idx_q;
    logic signed [AW-1:0]            acc_q, acc_d, r;
    logic signed [IN_WIDTH+GAIN_WIDTH:0] prod;
    logic signed [IN_WIDTH-1:0]      in_sh_q [COUNT];
    logic [GAIN_WIDTH-1:0]           gain_sh_q [COUNT];
    logic [GAIN_WIDTH-1:0]           gain_q [COUNT];
    logic signed [OUT_WIDTH-1:0]     out_q, out_d;
    logic                            busy_q, valid_q;

    always_comb begin
        prod  = in_sh_q[idx_q] * $signed({1'b0, gain_sh_q[idx_q]});
        acc_d = acc_q + AW'(prod);
        r     = acc_q >>> (GAIN_WIDTH - 1);
        out_d = r > OMAX ? OMAX[OUT_WIDTH-1:0] : r < OMIN ? OMIN[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int n = 0; n < COUNT; n++) begin
                gain_q[n]    <= UNITY;
                gain_sh_q[n] <= UNITY;
                in_sh_q[n]   <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (bus.gain_we_i && 32'(bus.gain_addr_i) < COUNT)
                gain_q[bus.gain_addr_i] <= bus.gain_data_i;
            case (state_q)
                IDLE: if (bus.start_i) begin
                    for (int n = 0; n < COUNT; n++) begin
                        in_sh_q[n]   <= bus.in_i[n*IN_WIDTH +: IN_WIDTH];
                        gain_sh_q[n] <= gain_q[n];
                    end
                    acc_q   <= '0;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IW'(COUNT - 1)) state_q <= LIMIT;
                end
                default: begin
                    out_q   <= out_d;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SOUND_MIXER_CLIP_EN
    logic clip_q, sat;
    assign sat = r > OMAX || r < OMIN;
    // Saturation beats a simultaneous clear so no clip event is lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) clip_q <= 1'b0;
        else if (state_q == LIMIT && sat) clip_q <= 1'b1;
        else if (bus.clip_clr_i) clip_q <= 1'b0;
    end
    assign bus.clip_o = clip_q;
`else
    logic unused_clip_clr;
    assign unused_clip_clr = bus.clip_clr_i;
    assign bus.clip_o = 1'b0;
`endif

    assign bus.busy_o      = busy_q;
    assign bus.out_o       = out_q;
    assign bus.out_valid_o = valid_q;
endmodule
